// File: rtl/prog_fetch_unit.sv
// ---------------------------------------------------------------------------
// prog_fetch_unit
//
// Instruction fetch front end sitting between a synchronous-read program
// memory and the decode stage. A program counter issues reads ahead of
// decode, returned words are queued together with their address, and the
// queue drains to decode over a valid/ready handshake. A redirect flushes
// the queue and any read in flight and restarts fetch at the target.
//
// Optional feature macro: PFU_PERF_CNT_EN (adds fetch_cnt / stall_cnt).
//
// Ports
//   clk             in   clock, all state on the rising edge
//   reset           in   asynchronous active-high reset
//   redirect_valid  in   jump taken this cycle
//   redirect_pc     in   jump target
//   mem_en          out  program memory read strobe
//   mem_addr        out  program memory read address
//   mem_rdata       in   memory data, valid the cycle after mem_en
//   ins_valid       out  queue head holds a valid instruction
//   ins_ready       in   decode accepts the head (low = stall)
//   ins             out  head instruction, zero when ins_valid=0
//   ins_pc          out  head instruction address, zero when ins_valid=0
//   fetch_cnt       out  (PFU_PERF_CNT_EN) number of instructions delivered
//   stall_cnt       out  (PFU_PERF_CNT_EN) cycles with ins_valid & !ins_ready
//
// Handshake: an instruction transfers to decode in every cycle where
// ins_valid and ins_ready are both high at the rising edge. ins_valid,
// ins and ins_pc depend on registered state only and never on ins_ready;
// once ins_valid is high the head stays unchanged until it transfers,
// a redirect is taken, or reset is asserted.
// ---------------------------------------------------------------------------
module prog_fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int INS_W    = 32,
    parameter int FQ_DEPTH = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_pc
`ifdef PFU_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(FQ_DEPTH);

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fq_pc_q  [FQ_DEPTH];
    logic [INS_W-1:0]  fq_ins_q [FQ_DEPTH];

    logic              pop;
    logic              push;
    logic [CNT_W:0]    demand;

    // Head presentation depends only on registered state.
    assign ins_valid = (count_q != '0);
    assign ins       = ins_valid ? fq_ins_q[rd_ptr_q] : '0;
    assign ins_pc    = ins_valid ? fq_pc_q[rd_ptr_q]  : '0;

    always_comb begin
        pop  = ins_valid & ins_ready;
        // A response landing in a redirect cycle belongs to the abandoned
        // path and is dropped.
        push = inflight_q & ~redirect_valid;

        // Slots already promised: queued entries plus the read in flight,
        // minus the entry leaving this cycle. Issuing only while this is
        // below the depth means a push can never meet a full queue.
        demand = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

        mem_en   = ~reset & (redirect_valid | (demand < DEPTH_C));
        mem_addr = reset          ? RESET_ADDR  :
                   redirect_valid ? redirect_pc : fetch_pc_q;

        fetch_pc_d = mem_en ? mem_addr + 1'b1 : fetch_pc_q;
        inflight_d = mem_en;
        tag_d      = mem_en ? mem_addr : tag_q;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        if (redirect_valid) begin
            // Everything except a same-cycle pop is discarded; restart the
            // read side where the write side stands so the queue is empty.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_ADDR;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_q[i]  <= '0;
                fq_ins_q[i] <= '0;
            end
        end else if (push) begin
            fq_pc_q[wr_ptr_q]  <= tag_q;
            fq_ins_q[wr_ptr_q] <= mem_rdata;
        end
    end

`ifdef PFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(pop);
            stall_cnt_q <= stall_cnt_q + 32'(ins_valid & ~ins_ready);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_prog_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_prog_fetch_unit
//
// Bench for prog_fetch_unit with a behavioural program memory
// (word[a] = a + 0x1000). Directed phases walk through reset, first fetch,
// stall/fill, redirects (with and without a same-cycle pop), address wrap
// and an asynchronous reset; a randomized phase follows. A monitor keeps
// the expected stream of delivered addresses in exp_q: consecutive
// addresses from RESET_PC, restarted at the target after every redirect.
// ---------------------------------------------------------------------------
module tb_prog_fetch_unit;

    localparam int ADDR_W   = 16;
    localparam int INS_W    = 32;
    localparam int FQ_DEPTH = 4;
    localparam int RESET_PC = 0;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [INS_W-1:0]  mem_rdata = '0;
    logic              ins_valid;
    logic              ins_ready;
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] ins_pc;
`ifdef PFU_PERF_CNT_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       stall_cnt;
`endif

    prog_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .INS_W   (INS_W),
        .FQ_DEPTH(FQ_DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ins           (ins),
        .ins_pc        (ins_pc)
`ifdef PFU_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    function automatic logic [INS_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return INS_W'(a) + 32'h1000;
    endfunction

    // Synchronous-read program memory; junk on the bus when not read so a
    // push in the wrong cycle is visible.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= word_of(mem_addr);
        else        mem_rdata <= $urandom;
    end

    // Scoreboard bookkeeping
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] next_pc;
    logic              stall_prev = 1'b0;
    logic [ADDR_W-1:0] stall_pc   = '0;
    int                model_fetch = 0;
    int                model_stall = 0;

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 1'b1;
        end
    endtask

    // Monitor: compares every delivered instruction against the reference
    // stream, checks NOP outputs and head stability under stall.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] e;
        if (reset) begin
            check("rst_ins_valid", 64'(ins_valid), 64'd0);
            check("rst_mem_en", 64'(mem_en), 64'd0);
            exp_q.delete();
            next_pc     = ADDR_W'(RESET_PC);
            stall_prev  = 1'b0;
            model_fetch = 0;
            model_stall = 0;
        end else begin
            if (!ins_valid) begin
                check("nop_ins", 64'(ins), 64'd0);
                check("nop_ins_pc", 64'(ins_pc), 64'd0);
            end
            if (stall_prev) begin
                check("stall_hold_valid", 64'(ins_valid), 64'd1);
                check("stall_hold_pc", 64'(ins_pc), 64'(stall_pc));
            end
            if (ins_valid && ins_ready) begin
                e = exp_q.pop_front();
                check("stream_pc", 64'(ins_pc), 64'(e));
                check("stream_ins", 64'(ins), 64'(word_of(e)));
                model_fetch++;
            end
            if (ins_valid && !ins_ready) model_stall++;
            stall_prev = ins_valid && !ins_ready && !redirect_valid;
            stall_pc   = ins_pc;
            if (redirect_valid) begin
                exp_q.delete();
                next_pc = redirect_pc;
            end
        end
        refill();
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    logic [ADDR_W-1:0] wrap_seq [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Driver
    initial begin
        int n_rd;
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1234;
        ins_ready      = 1'b1;
        next_pc        = ADDR_W'(RESET_PC);

        // Reset state, reset beats redirect
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_mem_en", 64'(mem_en), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'(RESET_PC));
        check("reset_ins_valid", 64'(ins_valid), 64'd0);
        check("reset_ins", 64'(ins), 64'd0);
        check("reset_ins_pc", 64'(ins_pc), 64'd0);

        // First fetch and streaming
        @(posedge clk); #1;
        reset = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check("first_issue_en", 64'(mem_en), 64'd1);
        check("first_issue_addr", 64'(mem_addr), 64'(RESET_PC));
        check("first_c0_valid", 64'(ins_valid), 64'd0);
        @(negedge clk);
        check("first_c1_valid", 64'(ins_valid), 64'd0);
        @(negedge clk);
        check("first_c2_valid", 64'(ins_valid), 64'd1);
        check("first_c2_pc", 64'(ins_pc), 64'(RESET_PC));
        repeat (6) begin
            @(negedge clk);
            check("stream_valid", 64'(ins_valid), 64'd1);
        end

        // Stall / fill from a fresh reset
        @(posedge clk); #1;
        reset = 1'b1; ins_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n_rd = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_en) n_rd++;
        end
        check("fill_reads", 64'(n_rd), 64'(FQ_DEPTH));
        check("fill_mem_en", 64'(mem_en), 64'd0);
        check("fill_head_valid", 64'(ins_valid), 64'd1);
        check("fill_head_pc", 64'(ins_pc), 64'(RESET_PC));

        // Release: pcs 0..4 back to back
        @(posedge clk); #1;
        ins_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("release_no_gap", 64'(ins_valid), 64'd1);
        end

        // Redirect with queue holding 5..7 and 8 in flight, no pop
        @(posedge clk); #1;
        ins_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        check("redir_head_pc", 64'(ins_pc), 64'd5);
        @(posedge clk); #1;
        redirect_valid = 1'b0; ins_ready = 1'b1;
        @(negedge clk);
        check("redir_r1_valid", 64'(ins_valid), 64'd0);
        @(negedge clk);
        check("redir_r2_valid", 64'(ins_valid), 64'd1);
        check("redir_r2_pc", 64'(ins_pc), 64'h0040);
        repeat (4) @(negedge clk);

        // Redirect with a same-cycle pop
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        check("popredir_valid", 64'(ins_valid), 64'd1);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("popredir_r1_valid", 64'(ins_valid), 64'd0);
        @(negedge clk);
        check("popredir_r2_pc", 64'(ins_pc), 64'h0100);
        repeat (3) @(negedge clk);

        // Address wrap
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_valid", 64'(ins_valid), 64'd1);
            check("wrap_pc", 64'(ins_pc), 64'(wrap_seq[i]));
        end

        // Asynchronous reset between edges with a non-empty queue
        @(negedge clk);
        check("prerst_valid", 64'(ins_valid), 64'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("arst_ins_valid", 64'(ins_valid), 64'd0);
        check("arst_ins", 64'(ins), 64'd0);
        check("arst_mem_en", 64'(mem_en), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
`ifdef PFU_PERF_CNT_EN
        check("arst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0; ins_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("arst_restart_valid", 64'(ins_valid), 64'd1);
        check("arst_restart_pc", 64'(ins_pc), 64'(RESET_PC));

        // Randomized traffic
        repeat (600) begin
            @(posedge clk); #1;
            ins_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ADDR_W'($urandom);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0; ins_ready = 1'b1;
        repeat (6) @(negedge clk);

`ifdef PFU_PERF_CNT_EN
        @(posedge clk); #1;
        check("perf_fetch_cnt", 64'(fetch_cnt), 64'(model_fetch));
        check("perf_stall_cnt", 64'(stall_cnt), 64'(model_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
